// File: rtl/exu_iter.sv
// rtl/exu_iter.sv - integer execute unit: 1-cycle ALU ops plus iterative MUL/DIVU/REMU
module exu_iter #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         op_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               rd_we_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    rd_data_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               rd_we_o,
  output logic               busy_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  // MUL: opa = shifted multiplicand, opb = shifted multiplier, acc = product
  // DIV: opa = dividend shifting out MSB-first / quotient shifting in, opb = divisor, acc = remainder
  logic [XLEN-1:0]     opa;
  logic [XLEN-1:0]     opb;
  logic [XLEN-1:0]     acc;
  logic                is_rem;
  logic [RADDR_W-1:0]  tag_addr;
  logic                tag_we;

  logic                accept;
  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     alu_res;
  logic [XLEN-1:0]     mul_acc_nxt;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       diff;
  logic                div_ge;
  logic [XLEN-1:0]     rem_nxt;
  logic [XLEN-1:0]     quo_nxt;

  // New work only in IDLE and only when the output register is empty or draining
  assign ready_o = (state == IDLE) && (!valid_o || ready_i);
  assign accept  = valid_i && ready_o;
  assign busy_o  = (state != IDLE);
  assign shamt   = rs2_data_i[SHW-1:0];

  // Single-cycle operations; unused opcodes produce zero
  always_comb begin
    alu_res = '0;
    case (op_i)
      4'd0:    alu_res = rs1_data_i | rs2_data_i;
      4'd1:    alu_res = rs1_data_i & rs2_data_i;
      4'd2:    alu_res = rs1_data_i ^ rs2_data_i;
      4'd3:    alu_res = rs1_data_i + rs2_data_i;
      4'd4:    alu_res = rs1_data_i - rs2_data_i;
      4'd5:    alu_res = rs1_data_i << shamt;
      4'd6:    alu_res = rs1_data_i >> shamt;
      4'd7:    alu_res = $signed(rs1_data_i) >>> shamt;
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data_i) < $signed(rs2_data_i))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (rs1_data_i < rs2_data_i)};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step and one restoring-divide step, evaluated from current state.
  // A zero divisor never borrows, so quotient saturates to all ones and remainder equals the dividend.
  always_comb begin
    mul_acc_nxt = opb[0] ? (acc + opa) : acc;
    rem_sh      = {acc, opa[XLEN-1]};
    diff        = rem_sh - {1'b0, opb};
    div_ge      = !diff[XLEN];
    rem_nxt     = div_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt     = {opa[XLEN-2:0], div_ge};
  end

  // Control FSM, iteration datapath and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      is_rem    <= 1'b0;
      tag_addr  <= '0;
      tag_we    <= 1'b0;
      valid_o   <= 1'b0;
      rd_data_o <= '0;
      rd_addr_o <= '0;
      rd_we_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_i == 4'd10 || op_i == 4'd11 || op_i == 4'd12) begin
              opa      <= rs1_data_i;
              opb      <= rs2_data_i;
              acc      <= '0;
              is_rem   <= (op_i == 4'd12);
              tag_addr <= rd_addr_i;
              tag_we   <= rd_we_i;
              cnt      <= CW'(XLEN);
              valid_o  <= 1'b0;
              state    <= (op_i == 4'd10) ? MUL : DIV;
            end else begin
              rd_data_o <= alu_res;
              rd_addr_o <= rd_addr_i;
              rd_we_o   <= rd_we_i;
              valid_o   <= 1'b1;
            end
          end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
          end
        end
        MUL: begin
          acc <= mul_acc_nxt;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rd_data_o <= mul_acc_nxt;
            rd_addr_o <= tag_addr;
            rd_we_o   <= tag_we;
            valid_o   <= 1'b1;
            state     <= IDLE;
          end
        end
        DIV: begin
          acc <= rem_nxt;
          opa <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rd_data_o <= is_rem ? rem_nxt : quo_nxt;
            rd_addr_o <= tag_addr;
            rd_we_o   <= tag_we;
            valid_o   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
